// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: classifies each retiring instruction into a typed, INUM-stamped record and queues it for a valid/ready consumer.
// Optional macro RETIRE_TRACE_NOP_FILTER_EN suppresses NOP records (they still consume an INUM).
module retire_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ret_valid,
  input  logic [PC_W-1:0]   ret_pc,
  input  logic              ret_regwrite,
  input  logic [REG_W-1:0]  ret_wreg,
  input  logic [DATA_W-1:0] ret_wdata,
  input  logic              ret_memread,
  input  logic              ret_memwrite,
  input  logic [PC_W-1:0]   ret_maddr,
  input  logic [DATA_W-1:0] ret_mdata,
  input  logic              ret_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_type,
  output logic [CNT_W-1:0]  out_inum,
  output logic [PC_W-1:0]   out_pc,
  output logic [REG_W-1:0]  out_reg,
  output logic [DATA_W-1:0] out_rval,
  output logic [PC_W-1:0]   out_addr,
  output logic [DATA_W-1:0] out_mval,
  output logic              halted,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] T_NOP = 3'd0, T_REG = 3'd1, T_LOAD = 3'd2,
                         T_STORE = 3'd3, T_STU = 3'd4, T_HALT = 3'd5;

  localparam logic [1:0] S_RUN = 2'd0, S_HALTED = 2'd1, S_DRAINED = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [CNT_W-1:0]  inum_q, inum_d, drop_q, drop_d, cycle_q, cycle_d;
  logic              ovf_q, ovf_d;

  logic [2:0]        type_mem [DEPTH];
  logic [CNT_W-1:0]  inum_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [REG_W-1:0]  reg_mem  [DEPTH];
  logic [DATA_W-1:0] rval_mem [DEPTH];
  logic [PC_W-1:0]   addr_mem [DEPTH];
  logic [DATA_W-1:0] mval_mem [DEPTH];

  logic [2:0]        rec_type;
  logic [REG_W-1:0]  rec_reg;
  logic [DATA_W-1:0] rec_rval, rec_mval;
  logic [PC_W-1:0]   rec_addr;
  logic              accept, filtered, push_req, push, pop, full, drop;

  // Fields that are meaningless for a record type are zeroed so the dumper can diff records directly.
  always_comb begin
    rec_type = T_NOP;
    rec_reg  = '0;
    rec_rval = '0;
    rec_addr = '0;
    rec_mval = '0;
    if (ret_regwrite && ret_memwrite) begin
      rec_type = T_STU;
      rec_reg  = ret_wreg;
      rec_rval = ret_wdata;
      rec_addr = ret_maddr;
      rec_mval = ret_mdata;
    end else if (ret_regwrite && ret_memread) begin
      rec_type = T_LOAD;
      rec_reg  = ret_wreg;
      rec_rval = ret_wdata;
      rec_addr = ret_maddr;
    end else if (ret_regwrite) begin
      rec_type = T_REG;
      rec_reg  = ret_wreg;
      rec_rval = ret_wdata;
    end else if (ret_halt) begin
      rec_type = T_HALT;
    end else if (ret_memwrite) begin
      rec_type = T_STORE;
      rec_addr = ret_maddr;
      rec_mval = ret_mdata;
    end
  end

`ifdef RETIRE_TRACE_NOP_FILTER_EN
  assign filtered = (rec_type == T_NOP);
`else
  assign filtered = 1'b0;
`endif

  assign accept    = ret_valid && (state_q == S_RUN);
  assign push_req  = accept && !filtered;
  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    inum_d  = accept ? inum_q + CNT_W'(1) : inum_q;
    drop_d  = (drop && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
    ovf_d   = ovf_q || drop;
    cycle_d = cycle_q + CNT_W'(1);
    state_d = state_q;
    case (state_q)
      S_RUN:    if (accept && ret_halt) state_d = S_HALTED;
      S_HALTED: if (count_d == '0) state_d = S_DRAINED;
      default:  state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      inum_q  <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      inum_q  <= inum_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  // Storage needs no reset: the payload is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      type_mem[wptr_q] <= rec_type;
      inum_mem[wptr_q] <= inum_q;
      pc_mem[wptr_q]   <= ret_pc;
      reg_mem[wptr_q]  <= rec_reg;
      rval_mem[wptr_q] <= rec_rval;
      addr_mem[wptr_q] <= rec_addr;
      mval_mem[wptr_q] <= rec_mval;
    end
  end

  assign out_type    = out_valid ? type_mem[rptr_q] : '0;
  assign out_inum    = out_valid ? inum_mem[rptr_q] : '0;
  assign out_pc      = out_valid ? pc_mem[rptr_q]   : '0;
  assign out_reg     = out_valid ? reg_mem[rptr_q]  : '0;
  assign out_rval    = out_valid ? rval_mem[rptr_q] : '0;
  assign out_addr    = out_valid ? addr_mem[rptr_q] : '0;
  assign out_mval    = out_valid ? mval_mem[rptr_q] : '0;
  assign halted      = (state_q != S_RUN);
  assign done        = (state_q == S_DRAINED);
  assign overflow    = ovf_q;
  assign drop_count  = drop_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomised bench for retire_trace_buffer (DEPTH=4) against a queue-based reference model of the trace rules.
module tb_retire_trace_buffer;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        ret_valid, ret_regwrite, ret_memread, ret_memwrite, ret_halt, out_ready;
  logic [15:0] ret_pc, ret_wdata, ret_maddr, ret_mdata;
  logic [2:0]  ret_wreg;
  logic        out_valid, halted, done, overflow;
  logic [2:0]  out_type, out_reg;
  logic [31:0] out_inum, drop_count, cycle_count;
  logic [15:0] out_pc, out_rval, out_addr, out_mval;

  retire_trace_buffer #(.DEPTH(DEPTH), .PC_W(16), .DATA_W(16), .REG_W(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_regwrite(ret_regwrite),
    .ret_wreg(ret_wreg), .ret_wdata(ret_wdata), .ret_memread(ret_memread),
    .ret_memwrite(ret_memwrite), .ret_maddr(ret_maddr), .ret_mdata(ret_mdata),
    .ret_halt(ret_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_inum(out_inum), .out_pc(out_pc), .out_reg(out_reg), .out_rval(out_rval),
    .out_addr(out_addr), .out_mval(out_mval),
    .halted(halted), .done(done), .overflow(overflow),
    .drop_count(drop_count), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [2:0]  rg;
    logic [15:0] rv;
    logic [15:0] ad;
    logic [15:0] mv;
  } rec_t;

  rec_t        mq[$];
  logic [31:0] mInum, mDrop, mCyc;
  bit          mOvf, mHalted, mDone;
  int          checkCount = 0;
  int          errorCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Record as the trace rules define it: the type decides which fields survive.
  function automatic rec_t makeRec();
    rec_t r;
    r = '{t: 3'd0, inum: mInum, pc: ret_pc, rg: 3'd0, rv: 16'd0, ad: 16'd0, mv: 16'd0};
    if (ret_regwrite && ret_memwrite)     r.t = 3'd4;
    else if (ret_regwrite && ret_memread) r.t = 3'd2;
    else if (ret_regwrite)                r.t = 3'd1;
    else if (ret_halt)                    r.t = 3'd5;
    else if (ret_memwrite)                r.t = 3'd3;
    if (r.t inside {3'd1, 3'd2, 3'd4}) begin r.rg = ret_wreg; r.rv = ret_wdata; end
    if (r.t inside {3'd2, 3'd3, 3'd4}) r.ad = ret_maddr;
    if (r.t inside {3'd3, 3'd4}) r.mv = ret_mdata;
    return r;
  endfunction

  task automatic checkAll();
    rec_t h;
    h = '{t: 3'd0, inum: 32'd0, pc: 16'd0, rg: 3'd0, rv: 16'd0, ad: 16'd0, mv: 16'd0};
    if (mq.size() != 0) h = mq[0];
    checkOutput("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    checkOutput("out_type", 64'(out_type), 64'(h.t));
    checkOutput("out_inum", 64'(out_inum), 64'(h.inum));
    checkOutput("out_pc", 64'(out_pc), 64'(h.pc));
    checkOutput("out_reg", 64'(out_reg), 64'(h.rg));
    checkOutput("out_rval", 64'(out_rval), 64'(h.rv));
    checkOutput("out_addr", 64'(out_addr), 64'(h.ad));
    checkOutput("out_mval", 64'(out_mval), 64'(h.mv));
    checkOutput("halted", 64'(halted), 64'(mHalted));
    checkOutput("done", 64'(done), 64'(mDone));
    checkOutput("overflow", 64'(overflow), 64'(mOvf));
    checkOutput("drop_count", 64'(drop_count), 64'(mDrop));
    checkOutput("cycle_count", 64'(cycle_count), 64'(mCyc));
  endtask

  // Advance the model by one clock with the inputs currently driven, then clock the DUT and compare.
  task automatic applyStimulus();
    rec_t r;
    bit   pop, full, accept, filt;
    if (rst) begin
      mq.delete();
      mInum = 0; mDrop = 0; mCyc = 0;
      mOvf = 0; mHalted = 0; mDone = 0;
    end else begin
      mCyc++;
      pop    = (mq.size() != 0) && out_ready;
      full   = (mq.size() == DEPTH);
      accept = ret_valid && !mHalted;
      r      = makeRec();
`ifdef RETIRE_TRACE_NOP_FILTER_EN
      filt = (r.t == 3'd0);
`else
      filt = 1'b0;
`endif
      if (pop) void'(mq.pop_front());
      if (accept) begin
        mInum++;
        if (!filt) begin
          if (!full || pop) mq.push_back(r);
          else begin
            mOvf = 1;
            if (mDrop != 32'hFFFF_FFFF) mDrop++;
          end
        end
      end
      if (mHalted && mq.size() == 0) mDone = 1;
      if (accept && ret_halt) mHalted = 1;
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic setRet(input bit v, rw, mr, mw, h, input logic [2:0] wreg,
                        input logic [15:0] pc, wdata, maddr, mdata);
    ret_valid = v; ret_regwrite = rw; ret_memread = mr; ret_memwrite = mw; ret_halt = h;
    ret_wreg = wreg; ret_pc = pc; ret_wdata = wdata; ret_maddr = maddr; ret_mdata = mdata;
  endtask

  task automatic doReset();
    rst = 1'b1;
    setRet(0, 0, 0, 0, 0, 3'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    applyStimulus();
    rst = 1'b0;
  endtask

  int readyPct [6] = '{90, 50, 10, 100, 30, 70};
  int doneHold;

  initial begin
    out_ready = 1'b0;
    doReset();
    doReset();

    // REG record appears one cycle after the push, then pops.
    setRet(1, 1, 0, 0, 0, 3'd3, 16'h0000, 16'h1234, 16'h0, 16'h0);
    applyStimulus();
    setRet(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    out_ready = 1'b1;
    applyStimulus();
    applyStimulus();

    // STU, LOAD, STORE, NOP, HALT with back-pressure, then drain.
    doReset();
    out_ready = 1'b0;
    setRet(1, 1, 0, 1, 0, 3'd1, 16'h0010, 16'h1111, 16'h0100, 16'h2222); applyStimulus();
    setRet(1, 1, 1, 0, 0, 3'd2, 16'h0012, 16'h3333, 16'h0102, 16'h4444); applyStimulus();
    setRet(1, 0, 0, 1, 0, 3'd4, 16'h0014, 16'h5555, 16'h0104, 16'h6666); applyStimulus();
    setRet(1, 0, 0, 0, 0, 3'd5, 16'h0016, 16'h7777, 16'h0106, 16'h8888); applyStimulus();
    setRet(1, 0, 0, 0, 1, 3'd6, 16'h0018, 16'h9999, 16'h0108, 16'hAAAA); applyStimulus();
    setRet(1, 1, 0, 0, 0, 3'd7, 16'h001A, 16'hBBBB, 16'h0, 16'h0);
    applyStimulus();
    out_ready = 1'b1;
    repeat (7) applyStimulus();

    // Overflow: six REG retirements into a four-entry FIFO, then push while popping.
    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      setRet(1, 1, 0, 0, 0, 3'(i), 16'(i * 2), 16'(i + 16'h100), 16'h0, 16'h0);
      applyStimulus();
    end
    out_ready = 1'b1;
    setRet(1, 1, 0, 0, 0, 3'd7, 16'h0040, 16'hBEEF, 16'h0, 16'h0);
    applyStimulus();

    // Reset while halted with three entries queued.
    doReset();
    out_ready = 1'b0;
    setRet(1, 1, 0, 0, 0, 3'd1, 16'h0002, 16'h0001, 16'h0, 16'h0); applyStimulus();
    setRet(1, 0, 0, 1, 0, 3'd0, 16'h0004, 16'h0, 16'h0200, 16'h0002); applyStimulus();
    setRet(1, 0, 0, 0, 1, 3'd0, 16'h0006, 16'h0, 16'h0, 16'h0); applyStimulus();
    setRet(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0); applyStimulus();
    doReset();
    setRet(1, 1, 0, 0, 0, 3'd2, 16'h0008, 16'h0ABC, 16'h0, 16'h0);
    applyStimulus();

    // Random phases with varying consumer back-pressure; occasional resets, forced after a long DRAINED hold.
    doneHold = 0;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 500; c++) begin
        out_ready = ($urandom_range(99) < readyPct[p]);
        setRet($urandom_range(99) < 70, $urandom_range(1), $urandom_range(1), $urandom_range(1),
               $urandom_range(49) == 0, 3'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom));
        doneHold = mDone ? doneHold + 1 : 0;
        rst = ($urandom_range(299) == 0) || (doneHold > 15);
        applyStimulus();
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
